compare_unit_pipe: RTL and testbench

//  Parametrised, pipelined successor of the single-cycle comparator in the MIPS datapath.

---
 rtl/compare_pkg.sv | 35 +++
 rtl/compare_core.sv | 50 +++++
 rtl/compare_unit_pipe.sv | 129 ++++++++++++
 tb/tb_compare_unit_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// compare_pkg
//   Shared definitions for the pipelined compare unit: opcode values, the
//   flag-combine mode encoding and the helper that applies a combine mode.
package compare_pkg;

  localparam int unsigned OP_ZERO   = 0;
  localparam int unsigned OP_PASS_A = 14;
  localparam int unsigned OP_PASS_B = 15;
  localparam int unsigned OP_EQ     = 17;
  localparam int unsigned OP_NE     = 18;
  localparam int unsigned OP_SLT    = 19;
  localparam int unsigned OP_SLTU   = 20;
  localparam int unsigned OP_SGE    = 21;
  localparam int unsigned OP_SGEU   = 22;

  typedef enum logic [1:0] {
    FM_REPLACE = 2'b00,
    FM_AND     = 2'b01,
    FM_OR      = 2'b10,
    FM_XOR     = 2'b11
  } flag_mode_t;

  function automatic logic combine_flag(input logic raw, input logic flag_in,
                                        input flag_mode_t mode);
    logic f;
    case (mode)
      FM_AND:  f = raw & flag_in;
      FM_OR:   f = raw | flag_in;
      FM_XOR:  f = raw ^ flag_in;
      default: f = raw;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/compare_core.sv
// compare_core
//   Combinational evaluator: maps (a, b, op) to a result word, the raw
//   compare bit and an undefined-opcode indication.
//   Ports:
//     a, b    in  WIDTH  operands
//     op      in  OP_W   opcode (values from compare_pkg)
//     result  out WIDTH  0/1 zero-extended for compares, A/B for pass ops
//     raw     out 1      compare outcome; 0 for zero/pass/undefined ops
//     op_err  out 1      op is not a defined opcode
module compare_core
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             raw,
  output logic             op_err
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    result = '0;
    raw    = 1'b0;
    op_err = 1'b0;
    case (op)
      OP_W'(OP_ZERO):   result = '0;
      OP_W'(OP_PASS_A): result = a;
      OP_W'(OP_PASS_B): result = b;
      OP_W'(OP_EQ):     raw = (a == b);
      OP_W'(OP_NE):     raw = (a != b);
      OP_W'(OP_SLT):    raw = lt_s;
      OP_W'(OP_SLTU):   raw = lt_u;
      OP_W'(OP_SGE):    raw = !lt_s;
      OP_W'(OP_SGEU):   raw = !lt_u;
      default:          op_err = 1'b1;
    endcase
    // raw is only ever set by compare ops, so it doubles as their result bit
    if (raw) result = {{(WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/compare_unit_pipe.sv
// compare_unit_pipe
//   Two-stage pipelined comparator with valid/ready on both sides.
//   S1 captures the operand beat, S2 holds the evaluated outputs.
//   Optional feature macro: COMPARE_STICKY_FLAG_EN (adds sticky_clr/sticky_flag).
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   operand handshake
//     a, b, op            operands and opcode
//     flag_in, flag_mode  chained flag and its combine mode
//     out_valid/out_ready result handshake
//     result              compare result or pass-through operand
//     flag_out            raw compare bit combined with flag_in
//     op_err              beat carried an undefined opcode
//     sticky_clr          (macro only) clear accumulated flag
//     sticky_flag         (macro only) OR of flag_out over output transfers
module compare_unit_pipe
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             flag_in,
  input  logic [1:0]       flag_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_out,
  output logic             op_err
`ifdef COMPARE_STICKY_FLAG_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_flag
`endif
);

  logic             rst_done;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;
  logic             s1_flag_in;
  flag_mode_t       s1_mode;

  logic [WIDTH-1:0] core_result;
  logic             core_raw;
  logic             core_err;
  logic             s2_load;

  compare_core #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .raw    (core_raw),
    .op_err (core_err)
  );

  // S2 may take a new beat when empty or when its current beat leaves now.
  assign s2_load  = !out_valid || out_ready;
  // rst_done holds off acceptance until the first edge after reset release.
  assign in_ready = rst_done && (!s1_valid || s2_load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done   <= 1'b0;
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_flag_in <= 1'b0;
      s1_mode    <= FM_REPLACE;
    end else begin
      rst_done <= 1'b1;
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a       <= a;
          s1_b       <= b;
          s1_op      <= op;
          s1_flag_in <= flag_in;
          s1_mode    <= flag_mode_t'(flag_mode);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_out  <= 1'b0;
      op_err    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= core_result;
        flag_out <= combine_flag(core_raw, s1_flag_in, s1_mode);
        op_err   <= core_err;
      end
    end
  end

`ifdef COMPARE_STICKY_FLAG_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  // A clear coinciding with a transfer keeps only that transfer's flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flag <= 1'b0;
    end else if (sticky_clr) begin
      sticky_flag <= out_xfer && flag_out;
    end else if (out_xfer) begin
      sticky_flag <= sticky_flag || flag_out;
    end
  end
`endif

endmodule

// File: tb/tb_compare_unit_pipe.sv
// tb_compare_unit_pipe
//   Directed-vector bench for compare_unit_pipe with hand-computed expectations.
module tb_compare_unit_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  op = '0;
  logic        flag_in = 1'b0;
  logic [1:0]  flag_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        flag_out;
  logic        op_err;
`ifdef COMPARE_STICKY_FLAG_EN
  logic        sticky_clr = 1'b0;
  logic        sticky_flag;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // captured output transfers: {result, flag_out, op_err}
  logic [33:0] q[$];

  always #5 clk = ~clk;

  compare_unit_pipe #(
    .WIDTH (32),
    .OP_W  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .flag_in   (flag_in),
    .flag_mode (flag_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_out  (flag_out),
    .op_err    (op_err)
`ifdef COMPARE_STICKY_FLAG_EN
    ,
    .sticky_clr  (sticky_clr),
    .sticky_flag (sticky_flag)
`endif
  );

  // inputs change only at posedge+1, so negedge sees the values of the next edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) q.push_back({result, flag_out, op_err});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] aa, input logic [31:0] bb, input logic [4:0] o,
                       input logic fi, input logic [1:0] fm);
    a = aa; b = bb; op = o; flag_in = fi; flag_mode = fm; in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic [4:0] o,
                      input logic fi, input logic [1:0] fm);
    logic acc;
    acc = 1'b0;
    drive(aa, bb, o, fi, fm);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 40 && q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() < n) chk("drain_timeout", 32'(q.size()), 32'(n));
  endtask

  task automatic chk_q(input string tag, input int idx, input logic [31:0] res,
                       input logic fl, input logic er);
    if (idx < q.size()) begin
      chk({tag, "_res"},  q[idx][33:2], res);
      chk({tag, "_flag"}, 32'(q[idx][1]), 32'(fl));
      chk({tag, "_err"},  32'(q[idx][0]), 32'(er));
    end else begin
      chk({tag, "_missing"}, 32'(q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flag", 32'(flag_out), 32'd0);
    chk("rst_err", 32'(op_err), 32'd0);
    rst = 1'b0;
    chk("rel_in_ready0", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready1", 32'(in_ready), 32'd1);
`ifdef COMPARE_STICKY_FLAG_EN
    chk("sticky_rst", 32'(sticky_flag), 32'd0);
`endif

    // EQ latency: out_valid one edge after the accepting edge
    send(32'h1234, 32'h1234, 5'd17, 1'b0, 2'b00);
    chk("eq_lat_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("eq_valid", 32'(out_valid), 32'd1);
    chk("eq_res", result, 32'd1);
    chk("eq_flag", 32'(flag_out), 32'd1);
    chk("eq_err", 32'(op_err), 32'd0);
    @(posedge clk);
    #1;
    q.delete();

    // signed vs unsigned ordering, including equal operands
    send(32'h8000_0000, 32'h7FFF_FFFF, 5'd19, 1'b0, 2'b00);
    send(32'h8000_0000, 32'h7FFF_FFFF, 5'd20, 1'b0, 2'b00);
    send(32'h8000_0000, 32'h7FFF_FFFF, 5'd21, 1'b0, 2'b00);
    send(32'h8000_0000, 32'h7FFF_FFFF, 5'd22, 1'b0, 2'b00);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 1'b0, 2'b00);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 1'b0, 2'b00);
    wait_q(6);
    chk_q("slt", 0, 32'd1, 1'b1, 1'b0);
    chk_q("sltu", 1, 32'd0, 1'b0, 1'b0);
    chk_q("sge", 2, 32'd0, 1'b0, 1'b0);
    chk_q("sgeu", 3, 32'd1, 1'b1, 1'b0);
    chk_q("slt_eq", 4, 32'd0, 1'b0, 1'b0);
    chk_q("sge_eq", 5, 32'd1, 1'b1, 1'b0);
    q.delete();

    // flag combine: NE on equal operands gives raw=0, flag_in=1
    for (int m = 0; m < 4; m++) send(32'd5, 32'd5, 5'd18, 1'b1, 2'(m));
    wait_q(4);
    chk_q("fm_replace", 0, 32'd0, 1'b0, 1'b0);
    chk_q("fm_and", 1, 32'd0, 1'b0, 1'b0);
    chk_q("fm_or", 2, 32'd0, 1'b1, 1'b0);
    chk_q("fm_xor", 3, 32'd0, 1'b1, 1'b0);
    q.delete();

    // pass-through, zero and undefined op (raw forced to 0)
    send(32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd14, 1'b1, 2'b00);
    send(32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd15, 1'b1, 2'b11);
    send(32'h7, 32'h7, 5'd5, 1'b1, 2'b10);
    send(32'h7, 32'h7, 5'd17, 1'b0, 2'b00);
    send(32'h9, 32'h9, 5'd0, 1'b1, 2'b01);
    wait_q(5);
    chk_q("pass_a", 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk_q("pass_b", 1, 32'h0BAD_F00D, 1'b1, 1'b0);
    chk_q("undef", 2, 32'd0, 1'b1, 1'b1);
    chk_q("after_undef", 3, 32'd1, 1'b1, 1'b0);
    chk_q("op_zero", 4, 32'd0, 1'b0, 1'b0);
    q.delete();

    // backpressure: out_ready low, 4 back-to-back beats
    out_ready = 1'b0;
    drive(32'd11, 32'd0, 5'd14, 1'b0, 2'b00);
    chk("bp_ready_empty", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(32'd22, 32'd0, 5'd14, 1'b0, 2'b00);
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(32'd33, 32'd0, 5'd14, 1'b0, 2'b00);
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_result_held", result, 32'd11);
      if (c < 2) begin
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    send(32'd33, 32'd0, 5'd14, 1'b0, 2'b00);
    send(32'd44, 32'd0, 5'd14, 1'b0, 2'b00);
    wait_q(4);
    for (int i = 0; i < 4; i++) chk_q("bp_order", i, 32'(11 * (i + 1)), 1'b0, 1'b0);
    q.delete();

    // reset with two beats in flight
    send(32'd1, 32'd1, 5'd17, 1'b1, 2'b10);
    send(32'd2, 32'd2, 5'd17, 1'b1, 2'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_flag", 32'(flag_out), 32'd0);
`ifdef COMPARE_STICKY_FLAG_EN
    chk("mid_rst_sticky", 32'(sticky_flag), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("no_stale_count", 32'(q.size()), 32'd0);
    chk("no_stale_valid", 32'(out_valid), 32'd0);

    // pipeline works again after reset
    send(32'd3, 32'd4, 5'd20, 1'b0, 2'b00);
    wait_q(1);
    chk_q("post_rst", 0, 32'd1, 1'b1, 1'b0);
`ifdef COMPARE_STICKY_FLAG_EN
    chk("sticky_set", 32'(sticky_flag), 32'd1);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    chk("sticky_clr", 32'(sticky_flag), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
